comp_fifo: RTL and testbench
============================

COMP_FIFO -- requirements
Module: comp_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream word present.
REQ-006 SHALL have port in_ready, output, 1, block accepts the upstream word this cycle.
REQ-007 SHALL have port in_raw, input, 128, uncompressed eight-lane x 16-bit word.
REQ-008 SHALL have port in_comp, input, 73, compressor output for in_raw.
REQ-009 SHALL have port in_doable, input, 1, compressor flag; in_comp is valid only when this is 1.
REQ-010 SHALL have port out_valid, output, 1, head word is available.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes the head word.
REQ-012 SHALL have port out_is_raw, output, 1; 1 selects out_raw, 0 selects out_comp for the decompressor.
REQ-013 SHALL have port out_comp, output, 73, compressed head payload.
REQ-014 SHALL have port out_raw, output, 128, raw head word.
REQ-015 SHALL have ports full and empty, output, 1 each, FIFO status.
REQ-016 SHALL have ports comp_cnt and raw_cnt, output, CNT_W each, counts of accepted compressed and raw words.

Function
REQ-017 SHALL store entries of 74 bits: bit 73 is the kind (0 = compressed, 1 = raw half); bits 72:0 are the payload.
REQ-018 SHALL, on an accept (in_valid & in_ready) with in_doable=1, write one entry {0, in_comp}.
REQ-019 SHALL, on an accept with in_doable=0, write {1, 9'b0, in_raw[63:0]} that cycle, register in_raw[127:64], and enter state W_HI.
REQ-020 SHALL, in W_HI, drive in_ready=0 and write {1, 9'b0, held[127:64]} on the first cycle with a free slot, then return to W_IDLE.
REQ-021 SHALL drive in_ready=1 only in W_IDLE with at least one free slot, regardless of in_doable.
REQ-022 SHALL use first-word fall-through: out_* are decoded combinationally from the head entry and the following entry.
REQ-023 SHALL drive out_valid=1 when the head is kind 0 and count>=1.
REQ-024 SHALL drive out_valid=1 when the head is kind 1 and count>=2, with out_raw = {entry[head+1][63:0], entry[head][63:0]}.
REQ-025 SHALL, when out_valid & out_ready, pop one entry for compressed and two entries for raw; pointers wrap modulo DEPTH.
REQ-026 SHALL drive out_comp to the head payload and out_raw to zero when out_is_raw=0, and out_comp to zero when out_is_raw=1.
REQ-027 SHALL allow push and pop in the same cycle, with count updated as count + push - pop (pop is 0, 1 or 2).
REQ-028 SHALL have full = (count==DEPTH) and empty = (count==0), and SHALL never overflow or underflow.
REQ-029 SHALL hold a raw word whose low half is written but whose high half is not yet written invisible (out_valid=0 if it is at the head).
REQ-030 SHALL increment comp_cnt or raw_cnt once per accepted word, saturating at all-ones.

Reset
REQ-031 SHALL, on reset, set the pointers, count, comp_cnt and raw_cnt to 0, and the write state to W_IDLE; storage contents are not cleared.
REQ-032 SHALL hold these values after reset: in_ready=1, out_valid=0, empty=1, full=0.
REQ-033 SHALL, on reset in W_HI, discard the pending raw half and the low half already written.
REQ-034 SHALL give reset priority over any simultaneous push or pop.

Verification
REQ-035 Scenario: one compressed push {doable=1, in_comp=73'h1_0000_0000_0000_0005}, out_ready=1 -> the next cycle gives out_valid=1, out_is_raw=0, out_comp equal to the value pushed; one cycle later empty=1 and comp_cnt=1.
REQ-036 Scenario: raw push in_raw=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, doable=0 -> in_ready=0 for one cycle; out_valid rises only after the second entry is written; out_raw equals in_raw; the pop removes two entries; raw_cnt=1.
REQ-037 Scenario: push 16 compressed words with out_ready=0 -> full=1 and in_ready=0; a 17th word is not accepted; then drain all 16 in order, with pointer wrap checked.
REQ-038 Scenario: count=DEPTH-1 and a raw push -> the low half fills the FIFO; W_HI stalls until one pop; the high half is written the cycle after the pop; the word is output intact.
REQ-039 Scenario: steady simultaneous push and pop of compressed words for 40 cycles -> count stays constant and there is no loss or reordering against the scoreboard.
REQ-040 Scenario: assert reset while in W_HI -> the next cycle gives empty=1, in_ready=1, comp_cnt=0, raw_cnt=0, and no stale output appears.

Source files
------------

// File: rtl/comp_fifo_if.sv
// comp_fifo_if
//   Handshake bundle between an upstream compressor, the comp_fifo buffer and
//   a downstream decompressor.
//
//   Upstream side (producer -> FIFO):
//     in_valid   word present
//     in_ready   FIFO accepts the word this cycle
//     in_raw     uncompressed eight-lane x 16-bit word
//     in_comp    compressor output for in_raw
//     in_doable  in_comp is usable; otherwise the raw word is stored
//   Downstream side (FIFO -> consumer):
//     out_valid  head word available
//     out_ready  consumer takes the head word
//     out_is_raw 1: use out_raw, 0: use out_comp
//     out_comp   compressed head payload
//     out_raw    raw head word
//
//   master: the environment (drives upstream data and out_ready).
//   slave:  the FIFO itself.
interface comp_fifo_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_raw;
  logic [72:0]  in_comp;
  logic         in_doable;
  logic         out_valid;
  logic         out_ready;
  logic         out_is_raw;
  logic [72:0]  out_comp;
  logic [127:0] out_raw;

  modport master (
    output in_valid, in_raw, in_comp, in_doable, out_ready,
    input  in_ready, out_valid, out_is_raw, out_comp, out_raw
  );

  modport slave (
    input  in_valid, in_raw, in_comp, in_doable, out_ready,
    output in_ready, out_valid, out_is_raw, out_comp, out_raw
  );
endinterface

// File: rtl/comp_fifo.sv
// comp_fifo
//   First-word-fall-through FIFO holding a mix of compressed and raw words.
//   Each entry is 74 bits: bit 73 is the kind (0 = compressed, 1 = raw half),
//   bits 72:0 the payload. A compressed word occupies one entry; a raw
//   128-bit word occupies two consecutive entries (low half, then high half),
//   written on two separate cycles so that only one write port is needed.
//
//   Ports:
//     clk       the only clock, rising edge
//     reset     synchronous active-high reset
//     bus       comp_fifo_if.slave handshake bundle (upstream + downstream)
//     full      count == DEPTH
//     empty     count == 0
//     comp_cnt  saturating count of accepted compressed words
//     raw_cnt   saturating count of accepted raw words
//
//   Parameters:
//     DEPTH     entry count, power of two, >= 4
//     CNT_W     width of the statistics counters
module comp_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  comp_fifo_if.slave       bus,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] comp_cnt,
  output logic [CNT_W-1:0] raw_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("comp_fifo: DEPTH must be a power of two and at least 4");
  end

  typedef enum logic {
    W_IDLE,
    W_HI
  } wr_state_t;

  wr_state_t     state_reg;
  wr_state_t     state_next;

  logic [73:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_plus1;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [AW:0]   pop_amt;
  logic [63:0]   hi_half_reg;

  logic          accept;
  logic          hi_write;
  logic          push;
  logic          pop;
  logic [73:0]   wr_data;
  logic [73:0]   head_entry;
  logic [73:0]   next_entry;
  logic          head_is_raw;
  logic [1:0]    stat_inc;

  // ---------------------------------------------------------------------------
  // Write side: accept, second-half write and the write-state machine.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    full         = (count_reg == FULL_COUNT);
    empty        = (count_reg == '0);
    // Ready never depends on in_doable: a raw word only needs one free slot
    // now, its high half waits in W_HI for the next free slot.
    bus.in_ready = (state_reg == W_IDLE) && !full;
    accept       = bus.in_valid && bus.in_ready;
    hi_write     = (state_reg == W_HI) && !full;
    push         = accept || hi_write;

    if (hi_write) begin
      wr_data = {1'b1, 9'b0, hi_half_reg};
    end else if (bus.in_doable) begin
      wr_data = {1'b0, bus.in_comp};
    end else begin
      wr_data = {1'b1, 9'b0, bus.in_raw[63:0]};
    end

    unique case (state_reg)
      W_IDLE: if (accept && !bus.in_doable) state_next = W_HI;
      W_HI:   if (!full) state_next = W_IDLE;
      default: state_next = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read side: fall-through decode of the head entry and the one after it.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_plus1   = rd_ptr_reg + AW'(1);
    head_entry     = mem[rd_ptr_reg];
    next_entry     = mem[rd_ptr_plus1];
    head_is_raw    = head_entry[73];

    // A raw head is only complete once its high half sits behind it, so a
    // raw low half with its partner still pending (count == 1) stays hidden.
    // Raw words are always written as adjacent pairs with nothing between.
    bus.out_valid  = (count_reg != '0) && (!head_is_raw || (count_reg >= (AW+1)'(2)));
    bus.out_is_raw = (count_reg != '0) && head_is_raw;
    bus.out_comp   = bus.out_is_raw ? 73'b0 : head_entry[72:0];
    bus.out_raw    = bus.out_is_raw ? {next_entry[63:0], head_entry[63:0]} : 128'b0;

    pop = bus.out_valid && bus.out_ready;
    if (!pop) begin
      pop_amt = '0;
    end else if (head_is_raw) begin
      pop_amt = (AW+1)'(2);
    end else begin
      pop_amt = (AW+1)'(1);
    end

    count_next = count_reg + (AW+1)'(push) - pop_amt;
  end

  // ---------------------------------------------------------------------------
  // Control state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= W_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_reg + pop_amt[AW-1:0];
      count_reg  <= count_next;
    end
  end

  // Storage and the held high half carry no reset; a reset simply rewinds
  // the pointers, which orphans whatever was in flight.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr_reg] <= wr_data;
    if (accept && !bus.in_doable) hi_half_reg <= bus.in_raw[127:64];
  end

  // ---------------------------------------------------------------------------
  // Statistics: index 0 counts compressed words, index 1 raw words.
  // ---------------------------------------------------------------------------
  assign stat_inc[0] = accept && bus.in_doable;
  assign stat_inc[1] = accept && !bus.in_doable;

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign comp_cnt = g_stat[0].cnt_reg;
  assign raw_cnt  = g_stat[1].cnt_reg;

endmodule

// File: tb/tb_comp_fifo.sv
// tb_comp_fifo
//   Self-checking bench for comp_fifo. The reference model keeps a queue of
//   whole words (compressed or raw) plus an entry occupancy figure; a raw
//   word is marked incomplete until its second entry has been written.
module tb_comp_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] comp_cnt;
  logic [CNT_W-1:0] raw_cnt;

  always #5 clk = ~clk;

  comp_fifo_if bus ();

  comp_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .full     (full),
    .empty    (empty),
    .comp_cnt (comp_cnt),
    .raw_cnt  (raw_cnt)
  );

  typedef struct {
    bit           raw;
    bit           done;
    logic [127:0] data;
  } word_t;

  word_t        mq[$];
  int           occ;
  int           m_comp;
  int           m_raw;
  bit           exp_ready;
  bit           exp_valid;
  bit           exp_is_raw;
  logic [127:0] exp_data;
  int           n_assert;
  int           n_fail;

  function automatic logic [72:0] rnd73();
    return 73'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_doable = 1'b0;
    bus.in_comp   = '0;
    bus.in_raw    = '0;
    bus.out_ready = 1'b0;
  endtask

  // Expected handshake/head values for the current model contents.
  task automatic model_eval();
    bit pend;
    pend       = (mq.size() > 0) && !mq[mq.size()-1].done;
    exp_ready  = !pend && (occ < DEPTH);
    exp_valid  = (mq.size() > 0) && mq[0].done;
    exp_is_raw = exp_valid && mq[0].raw;
    exp_data   = exp_valid ? mq[0].data : 128'b0;
  endtask

  // One clock: the model decides what the edge does from its own state and
  // the driven inputs, then the edge happens.
  task automatic tick();
    bit           pend;
    bit           pop;
    bit           acc;
    bit           din_doable;
    logic [127:0] din_raw;
    logic [72:0]  din_comp;
    int           occ_before;
    word_t        w;
    model_eval();
    pend       = (mq.size() > 0) && !mq[mq.size()-1].done;
    pop        = exp_valid && bus.out_ready;
    acc        = exp_ready && bus.in_valid;
    din_doable = bus.in_doable;
    din_raw    = bus.in_raw;
    din_comp   = bus.in_comp;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      occ    = 0;
      m_comp = 0;
      m_raw  = 0;
      return;
    end
    occ_before = occ;
    if (pop) begin
      occ -= mq[0].raw ? 2 : 1;
      void'(mq.pop_front());
    end
    if (pend) begin
      if (occ_before < DEPTH) begin
        mq[mq.size()-1].done = 1'b1;
        occ++;
      end
    end else if (acc) begin
      w.raw  = !din_doable;
      w.done = din_doable;
      w.data = din_doable ? {55'b0, din_comp} : din_raw;
      mq.push_back(w);
      occ++;
      if (din_doable) begin
        if (m_comp != (1 << CNT_W) - 1) m_comp++;
      end else begin
        if (m_raw != (1 << CNT_W) - 1) m_raw++;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_assert++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_assert++; if (comp_cnt !== '0 || raw_cnt !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", comp_cnt, raw_cnt); end
    $display("reset: in_ready=%b out_valid=%b empty=%b full=%b", bus.in_ready, bus.out_valid, empty, full);
  endtask

  task automatic test_comp_single();
    logic [72:0] v;
    v = 73'h1_0000_0000_0000_0005;
    drive_idle();
    bus.in_valid  = 1'b1;
    bus.in_doable = 1'b1;
    bus.in_comp   = v;
    bus.out_ready = 1'b1;
    #1;
    n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL comp1_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_assert++; if (bus.out_valid !== 1'b1 || bus.out_is_raw !== 1'b0) begin n_fail++; $display("FAIL comp1_head: got valid=%b is_raw=%b want 1/0", bus.out_valid, bus.out_is_raw); end
    n_assert++; if (bus.out_comp !== v) begin n_fail++; $display("FAIL comp1_data: got %h want %h", bus.out_comp, v); end
    n_assert++; if (bus.out_raw !== 128'b0) begin n_fail++; $display("FAIL comp1_raw_zero: got %h want 0", bus.out_raw); end
    tick();
    #1;
    n_assert++; if (empty !== 1'b1 || comp_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL comp1_after_pop: got empty=%b comp_cnt=%0d want 1/1", empty, comp_cnt); end
    $display("comp_single: pushed %h popped, comp_cnt=%0d", v, comp_cnt);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_raw_single();
    logic [127:0] r;
    r = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    drive_idle();
    bus.in_valid = 1'b1;
    bus.in_raw   = r;
    #1;
    n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw1_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_assert++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw1_half: got ready=%b valid=%b want 0/0", bus.in_ready, bus.out_valid); end
    tick();
    #1;
    n_assert++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_is_raw !== 1'b1) begin n_fail++; $display("FAIL raw1_whole: got ready=%b valid=%b is_raw=%b want 1/1/1", bus.in_ready, bus.out_valid, bus.out_is_raw); end
    n_assert++; if (bus.out_raw !== r || bus.out_comp !== 73'b0) begin n_fail++; $display("FAIL raw1_data: got %h/%h want %h/0", bus.out_raw, bus.out_comp, r); end
    n_assert++; if (raw_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL raw1_cnt: got %0d want 1", raw_cnt); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    n_assert++; if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw1_pop2: got empty=%b valid=%b want 1/0", empty, bus.out_valid); end
    $display("raw_single: word %h passed, raw_cnt=%0d", r, raw_cnt);
  endtask

  task automatic test_full();
    logic [72:0] saved[$];
    logic [72:0] v;
    int          cnt0;
    drive_idle();
    cnt0 = m_comp;
    bus.in_doable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = rnd73();
      saved.push_back(v);
      bus.in_valid = 1'b1;
      bus.in_comp  = v;
      tick();
    end
    #1;
    n_assert++; if (full !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags: got full=%b ready=%b want 1/0", full, bus.in_ready); end
    bus.in_comp = rnd73();
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_assert++; if (full !== 1'b1 || comp_cnt !== CNT_W'(cnt0 + DEPTH)) begin n_fail++; $display("FAIL full_reject: got full=%b comp_cnt=%0d want 1/%0d", full, comp_cnt, cnt0 + DEPTH); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_assert++; if (bus.out_valid !== 1'b1 || bus.out_comp !== saved[i]) begin n_fail++; $display("FAIL full_drain[%0d]: got valid=%b %h want 1 %h", i, bus.out_valid, bus.out_comp, saved[i]); end
      tick();
    end
    #1;
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty_after: got %b want 1", empty); end
    $display("full: %0d words filled and drained across pointer wrap", DEPTH);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_raw();
    logic [72:0]  saved[$];
    logic [127:0] r;
    drive_idle();
    bus.in_doable = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      saved.push_back(rnd73());
      bus.in_comp = saved[i];
      tick();
    end
    r = rnd128();
    bus.in_doable = 1'b0;
    bus.in_raw    = r;
    #1;
    n_assert++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fraw_accept: got ready=%b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    n_assert++; if (full !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fraw_stall: got full=%b ready=%b want 1/0", full, bus.in_ready); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    n_assert++; if (full !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fraw_after_pop: got full=%b ready=%b want 0/0", full, bus.in_ready); end
    tick();
    #1;
    n_assert++; if (full !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fraw_hi_written: got full=%b ready=%b want 1/0", full, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < DEPTH - 1; i++) begin
      #1;
      n_assert++; if (bus.out_valid !== 1'b1 || bus.out_comp !== saved[i]) begin n_fail++; $display("FAIL fraw_drain[%0d]: got valid=%b %h want 1 %h", i, bus.out_valid, bus.out_comp, saved[i]); end
      tick();
    end
    #1;
    n_assert++; if (bus.out_valid !== 1'b1 || bus.out_is_raw !== 1'b1 || bus.out_raw !== r) begin n_fail++; $display("FAIL fraw_word: got valid=%b is_raw=%b %h want 1/1 %h", bus.out_valid, bus.out_is_raw, bus.out_raw, r); end
    tick();
    #1;
    n_assert++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fraw_empty: got %b want 1", empty); end
    $display("full_raw: raw word %h survived stall at full", r);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stream();
    drive_idle();
    bus.in_doable = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_comp = rnd73();
      tick();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.in_comp = rnd73();
      #1;
      model_eval();
      n_assert++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_comp !== exp_data[72:0]) begin n_fail++; $display("FAIL stream[%0d]: got ready=%b valid=%b %h want 1/1 %h", c, bus.in_ready, bus.out_valid, bus.out_comp, exp_data[72:0]); end
      n_assert++; if (int'(dut.count_reg) != 4) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 4", c, dut.count_reg); end
      tick();
    end
    bus.in_valid = 1'b0;
    while (mq.size() > 0) begin
      #1;
      model_eval();
      n_assert++; if (bus.out_valid !== 1'b1 || bus.out_comp !== exp_data[72:0]) begin n_fail++; $display("FAIL stream_drain: got valid=%b %h want 1 %h", bus.out_valid, bus.out_comp, exp_data[72:0]); end
      tick();
    end
    $display("stream: 40 cycles of push+pop at constant depth, comp_cnt=%0d", comp_cnt);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int guard;
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_doable = ($urandom_range(0, 99) < 55);
      bus.in_comp   = rnd73();
      bus.in_raw    = rnd128();
      bus.out_ready = ($urandom_range(0, 99) < 45);
      #1;
      model_eval();
      n_assert++; if (bus.in_ready !== exp_ready || bus.out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_hs[%0d]: got ready=%b valid=%b want %b/%b", c, bus.in_ready, bus.out_valid, exp_ready, exp_valid); end
      if (exp_valid) begin
        n_assert++;
        if (exp_is_raw ? (bus.out_is_raw !== 1'b1 || bus.out_raw !== exp_data || bus.out_comp !== 73'b0)
                       : (bus.out_is_raw !== 1'b0 || bus.out_comp !== exp_data[72:0] || bus.out_raw !== 128'b0)) begin
          n_fail++; $display("FAIL rand_data[%0d]: got is_raw=%b comp=%h raw=%h want is_raw=%b data=%h", c, bus.out_is_raw, bus.out_comp, bus.out_raw, exp_is_raw, exp_data);
        end
      end
      n_assert++; if (full !== (occ == DEPTH) || empty !== (occ == 0)) begin n_fail++; $display("FAIL rand_flags[%0d]: got full=%b empty=%b want occ=%0d", c, full, empty, occ); end
      tick();
    end
    n_assert++; if (comp_cnt !== CNT_W'(m_comp) || raw_cnt !== CNT_W'(m_raw)) begin n_fail++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", comp_cnt, raw_cnt, m_comp, m_raw); end
    drive_idle();
    bus.out_ready = 1'b1;
    guard = 0;
    while (mq.size() > 0 && guard < 4 * DEPTH) begin
      tick();
      guard++;
    end
    #1;
    n_assert++; if (empty !== 1'b1 || mq.size() != 0) begin n_fail++; $display("FAIL rand_drain: got empty=%b model words left=%0d want 1/0", empty, mq.size()); end
    $display("random: 400 cycles, comp_cnt=%0d raw_cnt=%0d", comp_cnt, raw_cnt);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_whi();
    drive_idle();
    bus.in_valid = 1'b1;
    bus.in_raw   = rnd128();
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_assert++; if (empty !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rwhi_state: got empty=%b ready=%b valid=%b want 1/1/0", empty, bus.in_ready, bus.out_valid); end
    n_assert++; if (comp_cnt !== '0 || raw_cnt !== '0) begin n_fail++; $display("FAIL rwhi_counters: got %0d/%0d want 0/0", comp_cnt, raw_cnt); end
    tick();
    tick();
    #1;
    n_assert++; if (empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rwhi_no_stale: got empty=%b valid=%b ready=%b want 1/0/1", empty, bus.out_valid, bus.in_ready); end
    $display("reset_whi: pending raw word discarded, empty=%b", empty);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    occ      = 0;
    m_comp   = 0;
    m_raw    = 0;
    reset    = 1'b1;
    drive_idle();
    test_reset();
    test_comp_single();
    test_raw_single();
    test_full();
    test_full_raw();
    test_stream();
    test_random();
    test_reset_whi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
